// File: rtl/pi_bus_master.sv
// pi_bus_master
// Pi-side bus initiator. Requests are buffered in a 2-entry FIFO and one
// request is launched per Pi slot, always at the slot's first cycle. The
// block drives address, write data, output enable and write enable to the
// bus, samples read data during the strobe, and returns a one-cycle
// completion pulse.
//
// Ports
//   clk16      : 16 MHz system clock (same as the slot timing generator)
//   reset      : asynchronous, active-high reset
//   pi_select  : Pi slot window (8 of 16 cycles)
//   pi_strobe  : memory strobe (slot cycles 2 and 3)
//   req_valid / req_ready / req_we / req_addr / req_wdata : request handshake
//   bus_addr / bus_wdata / bus_oe / bus_we : bus drive outputs
//   bus_rdata  : read data from the bus
//   rsp_valid  : one-cycle completion pulse
//   rsp_rdata  : last read data, held until the next read completes
//   busy       : a transaction is in flight
`timescale 1ns/1ps
module pi_bus_master #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk16,
  input  logic                  reset,
  input  logic                  pi_select,
  input  logic                  pi_strobe,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_oe,
  output logic                  bus_we,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Slot edge detection
  logic r_sel_d;
  logic r_stb_d;
  logic w_slot_start;
  logic w_strobe_end;
  logic w_slot_end;

  // Request FIFO
  logic                  r_fifo_we    [2];
  logic [ADDR_WIDTH-1:0] r_fifo_addr  [2];
  logic [DATA_WIDTH-1:0] r_fifo_wdata [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  r_init;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_launch;
  logic                  w_rsp;

  // Working registers of the in-flight transaction
  logic                  r_cur_we;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [DATA_WIDTH-1:0] r_cur_wdata;
  logic                  r_oe;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  assign w_slot_start = pi_select & ~r_sel_d;
  assign w_strobe_end = r_stb_d & ~pi_strobe;
  assign w_slot_end   = ~pi_select & r_sel_d;

  assign w_full  = (r_count == 2'd2);
  assign w_empty = (r_count == 2'd0);
  // r_init keeps ready low while in reset and for the first edge after it.
  assign req_ready = r_init & ~w_full;
  assign w_push    = req_valid & req_ready;

  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      r_sel_d <= 1'b0;
      r_stb_d <= 1'b0;
      r_init  <= 1'b0;
    end else begin
      r_sel_d <= pi_select;
      r_stb_d <= pi_strobe;
      r_init  <= 1'b1;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by r_count alone.
  always_ff @(posedge clk16) begin
    if (w_push) begin
      r_fifo_we[r_wr_ptr]    <= req_we;
      r_fifo_addr[r_wr_ptr]  <= req_addr;
      r_fifo_wdata[r_wr_ptr] <= req_wdata;
    end
  end

  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push)   r_wr_ptr <= ~r_wr_ptr;
      if (w_launch) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_launch})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state and strobes. The empty test uses the registered count,
  // so a request pushed in the slot-start cycle waits for the next slot.
  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    w_rsp    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_slot_start && !w_empty) begin
          w_next   = S_ACTIVE;
          w_launch = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (w_strobe_end) begin
          w_next = S_DRAIN;
          w_rsp  = 1'b1;
        end else if (w_slot_end) begin
          // Slot closed without a strobe: abandon silently.
          w_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_slot_end) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      r_cur_we    <= 1'b0;
      r_cur_addr  <= '0;
      r_cur_wdata <= '0;
      r_oe        <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_launch) begin
        r_cur_we    <= r_fifo_we[r_rd_ptr];
        r_cur_addr  <= r_fifo_addr[r_rd_ptr];
        r_cur_wdata <= r_fifo_wdata[r_rd_ptr];
        r_oe        <= r_fifo_we[r_rd_ptr];
      end else if (w_next == S_IDLE) begin
        r_oe <= 1'b0;
      end
      // Sampled on both strobe cycles; the second one leaves the final value.
      if (r_state == S_ACTIVE && !r_cur_we && pi_strobe)
        r_rsp_rdata <= bus_rdata;
    end
  end

  assign bus_addr  = r_cur_addr;
  assign bus_wdata = r_cur_wdata;
  assign bus_oe    = r_oe;
  assign bus_we    = (r_state == S_ACTIVE) & r_cur_we & pi_strobe;
  assign rsp_valid = w_rsp;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/pi_bus_master.md
# pi_bus_master

Pi-side bus initiator that consumes the bus-slot timing signals (`pi_select`, `pi_strobe`) and performs one queued memory transaction per Pi slot. Requests arrive from the SPI/Pi command path via a valid/ready handshake, are buffered in a 2-entry FIFO, and are launched only at the start of a Pi slot. Read data and a completion pulse return to the requester. The CPU-slot signals are not used here; this block idles during CPU slots.

## Interface
- `ADDR_WIDTH`, 17: memory address width.
- `DATA_WIDTH`, 8: data width.

- `clk16` in 1: 16 MHz system clock, the same clock as the slot timing generator.
- `reset` in 1: asynchronous, active-high reset.
- `pi_select` in 1: Pi slot window, high for 8 consecutive cycles out of 16.
- `pi_strobe` in 1: memory strobe, high for the 3rd and 4th cycles of the Pi slot.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_WIDTH: target address.
- `req_wdata` in DATA_WIDTH: write data.
- `bus_addr` out ADDR_WIDTH: address driven to RAM/IO.
- `bus_wdata` out DATA_WIDTH: write data to bus.
- `bus_oe` out 1: enable for bus data drivers.
- `bus_we` out 1: RAM write enable.
- `bus_rdata` in DATA_WIDTH: read data from bus.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out DATA_WIDTH: read data, held until the next completion.
- `busy` out 1: a transaction is in flight.

## Operation
- **FIFO.** 2 entries, each holding {we, addr, wdata}.
  - Push when `req_valid && req_ready`.
  - `req_ready = !full`.
  - Pop occurs on launch.
  - Simultaneous push and pop when full is not allowed, because ready is low. When the FIFO is empty, a push and a launch cannot coincide; the launch sees the entry only on the next slot start.
- **Slot detection.** Register `sel_d <= pi_select` and `stb_d <= pi_strobe`.
  - `slot_start = pi_select && !sel_d`
  - `strobe_end = stb_d && !pi_strobe`
  - `slot_end = !pi_select && sel_d`
- **FSM states.** IDLE, ACTIVE, DRAIN.
  - IDLE → ACTIVE: on `slot_start && !empty`. Pop the head entry into the working registers {cur_we, cur_addr, cur_wdata}.
  - ACTIVE → DRAIN: on `strobe_end`. Pulse `rsp_valid` for one cycle in that same edge's output.
  - DRAIN → IDLE: on `slot_end`.
  - A request that arrives mid-slot waits for the next `slot_start`. Launching mid-slot is never allowed.
- **Outputs.**
  - `busy` is high in ACTIVE and DRAIN.
  - `bus_addr = cur_addr`, registered and valid from the cycle after `slot_start` until `slot_end`.
  - `bus_oe` is registered: high in ACTIVE and DRAIN when `cur_we`, otherwise low.
  - `bus_wdata = cur_wdata`.
  - `bus_we = (state == ACTIVE) && cur_we && pi_strobe`. This is combinational and aligned exactly with the strobe cycles.
  - `rsp_rdata` loads `bus_rdata` on every clock edge where `state == ACTIVE && !cur_we && pi_strobe`, so the final value comes from the second strobe cycle. Writes leave `rsp_rdata` unchanged.
- **Reset.** The FSM goes to IDLE and the FIFO is emptied. The following are all 0: `sel_d`, `stb_d`, `bus_addr`, `bus_wdata`, `bus_oe`, `bus_we`, `rsp_valid`, `rsp_rdata`, `busy`. `req_ready` is 1 one cycle after reset deasserts. A reset during ACTIVE aborts the transaction with no `rsp_valid`, and the entry is lost.
- **Abnormal timing.** If `pi_select` falls while in ACTIVE (strobe never seen), the FSM goes to IDLE with no response. Normal timing never produces this.

## Timing
Slot cycles are numbered 0–7 within `pi_select` high.
- **Cycle 0:** `slot_start` is true. The launch decision is registered at the end of the cycle.
- **Cycle 1:** `bus_addr`, `bus_wdata` and `bus_oe` are valid. `busy` = 1.
- **Cycles 2–3:** `pi_strobe` is high, and `bus_we` follows it for writes. Read data is sampled at the end of cycles 2 and 3.
- **Cycle 4:** `rsp_valid` = 1 and `rsp_rdata` is final.
- **Cycles 5–7:** bus outputs are held.
- **First CPU-slot cycle:** `slot_end`. `bus_oe` and `busy` fall at the end of this cycle, so they are low from the second CPU cycle on. Write data is therefore held one cycle past the end of the slot.
- **Latency.** A request accepted before cycle 0 of a slot completes in that same slot, with `rsp_valid` 4 cycles after `slot_start`.
- **Throughput.** At most 1 transaction per 16 cycles.

## Test plan
- **Read from reset idle:** push a read of 0x08000 before slot start, with the bus model returning 0xA5 during the strobe. Required: `bus_addr` = 0x08000 at cycle 1, `bus_we` stays 0, `rsp_valid` at cycle 4, `rsp_rdata` = 0xA5.
- **Write:** push a write of 0x5A to 0x1FFFF. Required: `bus_oe` high cycles 1–8, `bus_we` high exactly at cycles 2–3, `bus_wdata` = 0x5A, `rsp_rdata` unchanged.
- **Back-to-back and full FIFO:** push 3 requests back-to-back from reset. Required: `req_ready` drops after 2 pushes. The three requests complete in 3 consecutive Pi slots, 16 cycles apart, in order.
- **Late request:** push a request at cycle 3 of an idle Pi slot. Required: nothing is driven in that slot; the request launches at the next `slot_start`.
- **Reset mid-transaction:** assert `reset` asynchronously at cycle 2 of a write. Required: `bus_we`, `bus_oe` and `busy` go to 0 immediately, no `rsp_valid`, FIFO empty afterwards.
